fifo_ctrl: RTL
==============

# fifo_ctrl

Synchronous FIFO controller that sequences the team's dual-port RAM (port 0 write-only, port 1 read-only) into a first-word-fall-through FIFO with ready/valid handshakes. It owns the write and read pointers, occupancy count, status flags and a post-reset/flush scrub of RAM contents. The RAM stays a separate instance, and this block drives all of its address, enable and direction pins.

## Interface
- DATA_RAM_WIDTH, 8: data word width; must match the RAM.
- ADDR_WIDTH, 8: RAM address width; DEPTH = 2^ADDR_WIDTH.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous; discards contents and restarts the scrub.
- push_valid  in  1  write request.
- push_ready  out  1  FIFO can accept a word.
- push_data  in  DATA_RAM_WIDTH  write word.
- pop_valid  out  1  head word available.
- pop_ready  in  1  consumer takes the head.
- pop_data  out  DATA_RAM_WIDTH  head word (combinational from ram_data_1).
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- busy  out  1  high while scrubbing.
- ram_addr_0  out  ADDR_WIDTH  RAM write address.
- ram_ce_0  out  1  RAM port 0 enable.
- ram_wr_0  out  1  RAM port 0 direction, tied 1.
- ram_data_0  out  DATA_RAM_WIDTH  RAM write data.
- ram_addr_1  out  ADDR_WIDTH  RAM read address.
- ram_ce_1  out  1  RAM port 1 enable.
- ram_wr_1  out  1  RAM port 1 direction, tied 0.
- ram_data_1  in  DATA_RAM_WIDTH  RAM read data.

## Operation
- State machine has two states, SCRUB and RUN.
  - Reset enters SCRUB with scrub_addr=0.
  - In SCRUB: ram_addr_0=scrub_addr, ram_ce_0=1, ram_data_0=0. scrub_addr increments each cycle.
  - After address DEPTH-1 is written, the FSM moves to RUN.
  - flush in any state enters SCRUB next cycle and clears the pointers.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the extra MSB is the wrap bit. The low bits drive ram_addr_0 and ram_addr_1.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- push_ready = RUN && !full. Full does not look ahead: a pop in the same cycle does not raise push_ready.
- Push fires on push_valid && push_ready.
  - In that cycle: ram_ce_0=1, ram_data_0=push_data.
  - Next edge: wr_ptr increments.
- pop_valid = RUN && !empty. Pop fires on pop_valid && pop_ready; rd_ptr increments on the next edge.
- ram_ce_1 = RUN && !empty. The RAM read only re-evaluates on address or enable changes, so ram_ce_1 must drop while empty. Its rising edge refreshes ram_data_1 with the first word.
- Outside a push or scrub, ram_ce_0=0 and ram_data_0=push_data.

## Timing
- Reset values:
  - FSM=SCRUB; pointers, count and scrub_addr = 0.
  - push_ready=0, pop_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, busy=1, ram_ce_0=1, ram_ce_1=0.
- Scrub lasts exactly DEPTH cycles after reset release or flush. busy deasserts in the first RUN cycle.
- Latency:
  - A pushed word becomes visible on pop_data, with pop_valid=1, one cycle after the push edge when the FIFO was empty.
  - Throughput is 1 push and 1 pop per cycle.
- Simultaneous events:
  - Push+pop while 0 < count < DEPTH: count unchanged, both pointers advance.
  - Push while empty: pop_valid stays 0 that cycle.
  - flush has priority over push and pop.
- Wrap: low bits roll from DEPTH-1 to 0 and the MSB toggles. No other special case.
- Reset mid-operation clears everything asynchronously. RAM contents are rewritten by the following scrub.

## Structure
- Shared package fifo_pkg holds:
  - typedef enum fifo_state_e {SCRUB, RUN};
  - a localparam function for DEPTH from ADDR_WIDTH.
- One sub-module, fifo_ptr: parameterised ADDR_WIDTH+1 pointer with increment and clear. It is instantiated twice.
- count and the flags are derived in fifo_ctrl from the two pointers.

## Test plan
All scenarios use ADDR_WIDTH=2, DATA_RAM_WIDTH=8, AF_LEVEL=3, AE_LEVEL=1.
- Reset, then wait: busy=1 for 4 cycles; ram_addr_0 sequences 0,1,2,3 with ram_data_0=0; then push_ready=1, empty=1, count=0.
- Push 0xA1,0xB2,0xC3,0xD4: full=1, count=4, almost_full from count 3, push_ready=0. A 5th push_valid is not accepted and count stays 4.
- Pop 4 with pop_ready=1: pop_data reads 0xA1,0xB2,0xC3,0xD4 in order; then empty=1, pop_valid=0.
- Push 0x55 into an empty FIFO: the next cycle shows pop_valid=1, pop_data=0x55.
- Continuous push+pop for 10 words (0x00..0x09) after one pre-load: count stays 1, pointers wrap twice, data order is preserved.
- flush with count=3: scrub for 4 cycles, then count=0 and empty=1. Reset asserted mid-scrub restarts the scrub at address 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: types and helpers shared by the FIFO controller files.
//   fifo_state_e : controller state (SCRUB clears RAM, RUN passes traffic)
//   fifo_depth() : number of RAM words for a given address width
package fifo_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } fifo_state_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: W-bit wrapping pointer with synchronous clear and increment.
//   clk   in  clock, rising edge
//   reset in  asynchronous active-high reset, pointer -> 0
//   clr   in  synchronous clear, wins over inc
//   inc   in  advance by one, wrapping modulo 2^W
//   ptr   out current pointer value
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequences a dual-port RAM (port 0 write, port 1 read) into a
// first-word-fall-through FIFO with ready/valid handshakes, and zero-fills
// the RAM after reset or flush.
//   clk, reset                : clock, asynchronous active-high reset
//   flush                     : synchronous discard + re-scrub
//   push_valid/ready/data     : write side handshake
//   pop_valid/ready/data      : read side handshake (pop_data = ram_data_1)
//   count, full, empty,
//   almost_full, almost_empty : occupancy and status
//   busy                      : high while scrubbing
//   ram_*_0                   : RAM write port drive
//   ram_*_1                   : RAM read port drive / read data
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_RAM_WIDTH = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int AF_LEVEL       = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AE_LEVEL       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [DATA_RAM_WIDTH-1:0] push_data,
  output logic                      pop_valid,
  input  logic                      pop_ready,
  output logic [DATA_RAM_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]       count,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      busy,
  output logic [ADDR_WIDTH-1:0]     ram_addr_0,
  output logic                      ram_ce_0,
  output logic                      ram_wr_0,
  output logic [DATA_RAM_WIDTH-1:0] ram_data_0,
  output logic [ADDR_WIDTH-1:0]     ram_addr_1,
  output logic                      ram_ce_1,
  output logic                      ram_wr_1,
  input  logic [DATA_RAM_WIDTH-1:0] ram_data_1
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  fifo_state_e           state;
  logic [ADDR_WIDTH-1:0] scrub_addr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  run;
  logic                  push_fire;
  logic                  pop_fire;

  // Scrub walks every address once, then hands over to normal traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SCRUB;
      scrub_addr <= '0;
    end else if (flush) begin
      state      <= SCRUB;
      scrub_addr <= '0;
    end else begin
      case (state)
        SCRUB: begin
          scrub_addr <= scrub_addr + ADDR_WIDTH'(1);
          if (&scrub_addr) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign run = (state == RUN);

  // flush outranks both handshakes, so a coinciding push never touches the RAM.
  assign push_fire = push_valid && push_ready && !flush;
  assign pop_fire  = pop_valid && pop_ready && !flush;

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (push_fire),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (pop_fire),
    .ptr   (rd_ptr)
  );

  // Status derived purely from the pointers; the MSB disambiguates full/empty.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);
  assign busy         = !run;

  assign push_ready = run && !full;
  assign pop_valid  = run && !empty;

  assign ram_wr_0   = 1'b1;
  assign ram_addr_0 = run ? wr_ptr[ADDR_WIDTH-1:0] : scrub_addr;
  assign ram_ce_0   = !run || push_fire;
  assign ram_data_0 = run ? push_data : '0;

  // The read port only refreshes on address/enable changes, so the enable
  // must drop while empty; its rise then fetches the first word.
  assign ram_wr_1   = 1'b0;
  assign ram_addr_1 = rd_ptr[ADDR_WIDTH-1:0];
  assign ram_ce_1   = run && !empty;
  assign pop_data   = ram_data_1;

endmodule
